// File: rtl/esm_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : esm_issue_scheduler_if
// Purpose  : Fetch/core/downstream signal bundle for the ESM issue scheduler.
// Revision : 1.0
// ============================================================================
interface esm_issue_scheduler_if #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16
);
  localparam int IDX_W = $clog2(bs);

  logic                       in_valid;
  logic [Instr_word_size-1:0] in_instr;
  logic                       in_ready;

  logic [Instr_word_size-1:0] alloc_instr;
  logic [IDX_W-1:0]           alloc_index;
  logic                       alloc_valid;
  logic [bs-1:0]              ready_positions;

  logic                       issue_valid;
  logic [Instr_word_size-1:0] issue_instr;
  logic [IDX_W-1:0]           issue_index;
  logic                       issue_ready;

  logic                       release_valid;
  logic [IDX_W-1:0]           release_index;

  logic [IDX_W:0]             count;
  logic                       full;
  logic                       empty;

  modport master (
    output in_valid, in_instr, ready_positions, issue_ready,
    input  in_ready, alloc_instr, alloc_index, alloc_valid,
           issue_valid, issue_instr, issue_index,
           release_valid, release_index, count, full, empty
  );

  modport slave (
    input  in_valid, in_instr, ready_positions, issue_ready,
    output in_ready, alloc_instr, alloc_index, alloc_valid,
           issue_valid, issue_instr, issue_index,
           release_valid, release_index, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/esm_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : esm_issue_scheduler
// Purpose  : Slot allocator and round-robin issuer in front of the ESM core.
// Revision : 1.0
// ============================================================================
module esm_issue_scheduler #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  esm_issue_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(bs);

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_TRACK = 2'd2,
    SLOT_OUT   = 2'd3
  } slot_state_t;

  slot_state_t                slot_state [bs];
  slot_state_t                slot_next  [bs];
  logic [Instr_word_size-1:0] slot_instr [bs];

  logic [IDX_W:0]             count_q;
  logic [IDX_W-1:0]           rr_q;

  logic                       alloc_valid_q;
  logic [Instr_word_size-1:0] alloc_instr_q;
  logic [IDX_W-1:0]           alloc_index_q;

  logic                       issue_valid_q;
  logic [Instr_word_size-1:0] issue_instr_q;
  logic [IDX_W-1:0]           issue_index_q;

  logic                       release_valid_q;
  logic [IDX_W-1:0]           release_index_q;

  logic                       full_w;
  logic                       accept;
  logic                       handshake;
  logic                       load;
  logic                       free_found;
  logic [IDX_W-1:0]           free_idx;
  logic [bs-1:0]              eligible;
  logic                       sel_found;
  logic [IDX_W-1:0]           sel_idx;

  assign full_w    = (count_q == (IDX_W+1)'(bs));
  assign accept    = bus.in_valid && !full_w;
  assign handshake = issue_valid_q && bus.issue_ready;
  assign load      = (!issue_valid_q || bus.issue_ready) && sel_found;

  // Descending scan so the lowest-index free slot is the one that sticks.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (slot_state[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  for (genvar g = 0; g < bs; g++) begin : g_eligible
    assign eligible[g] = (slot_state[g] == SLOT_TRACK) && bus.ready_positions[g];
  end

  // Round-robin: smallest offset from rr wins, offsets scanned high to low.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      cand = rr_q + IDX_W'(k);
      if (eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Per-slot next state; accept, load and handshake always touch distinct slots.
  always_comb begin
    for (int i = 0; i < bs; i++) begin
      slot_next[i] = slot_state[i];
      if (slot_state[i] == SLOT_PEND) begin
        slot_next[i] = SLOT_TRACK;
      end
      if (handshake && (issue_index_q == IDX_W'(i))) begin
        slot_next[i] = SLOT_FREE;
      end
      if (load && (sel_idx == IDX_W'(i))) begin
        slot_next[i] = SLOT_OUT;
      end
      if (accept && free_found && (free_idx == IDX_W'(i))) begin
        slot_next[i] = SLOT_PEND;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) begin
        slot_state[i] <= SLOT_FREE;
      end
    end else begin
      for (int i = 0; i < bs; i++) begin
        slot_state[i] <= slot_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_instr[free_idx] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_valid_q <= 1'b0;
      alloc_instr_q <= '0;
      alloc_index_q <= '0;
    end else begin
      alloc_valid_q <= accept;
      alloc_instr_q <= accept ? bus.in_instr : '0;
      alloc_index_q <= accept ? free_idx : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      issue_index_q <= '0;
      rr_q          <= '0;
    end else if (load) begin
      issue_valid_q <= 1'b1;
      issue_instr_q <= slot_instr[sel_idx];
      issue_index_q <= sel_idx;
      rr_q          <= sel_idx + 1'b1;
    end else if (handshake) begin
      issue_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      release_valid_q <= 1'b0;
      release_index_q <= '0;
    end else begin
      release_valid_q <= handshake;
      if (handshake) begin
        release_index_q <= issue_index_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      case ({accept, handshake})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.in_ready      = !full_w;
  assign bus.full          = full_w;
  assign bus.empty         = (count_q == '0);
  assign bus.count         = count_q;
  assign bus.alloc_valid   = alloc_valid_q;
  assign bus.alloc_instr   = alloc_instr_q;
  assign bus.alloc_index   = alloc_index_q;
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_instr   = issue_instr_q;
  assign bus.issue_index   = issue_index_q;
  assign bus.release_valid = release_valid_q;
  assign bus.release_index = release_index_q;

endmodule
`default_nettype wire

// File: tb/tb_esm_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_esm_issue_scheduler
// Purpose  : Directed self-checking bench for esm_issue_scheduler.
// Revision : 1.0
// ============================================================================
module tb_esm_issue_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  esm_issue_scheduler_if #(.Instr_word_size(32), .bs(16)) bus ();

  esm_issue_scheduler #(.Instr_word_size(32), .bs(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.ready_positions = '0;
    bus.issue_ready = 1'b0;

    // Reset values held while rst is low
    repeat (3) tick();
    chk("rst_issue_valid",   bus.issue_valid, 0);
    chk("rst_alloc_valid",   bus.alloc_valid, 0);
    chk("rst_alloc_instr",   bus.alloc_instr, 0);
    chk("rst_alloc_index",   bus.alloc_index, 0);
    chk("rst_release_valid", bus.release_valid, 0);
    chk("rst_release_index", bus.release_index, 0);
    chk("rst_issue_instr",   bus.issue_instr, 0);
    chk("rst_issue_index",   bus.issue_index, 0);
    chk("rst_count",         bus.count, 0);
    chk("rst_empty",         bus.empty, 1);
    chk("rst_full",          bus.full, 0);
    chk("rst_in_ready",      bus.in_ready, 1);
    #2 rst = 1'b1;

    // Idle after reset
    repeat (3) tick();
    chk("idle_alloc_instr", bus.alloc_instr, 0);
    chk("idle_alloc_valid", bus.alloc_valid, 0);
    chk("idle_in_ready",    bus.in_ready, 1);
    chk("idle_issue_valid", bus.issue_valid, 0);

    // Single independent instruction
    bus.ready_positions = '1;
    bus.issue_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0050_0093;
    tick();
    chk("one_alloc_valid", bus.alloc_valid, 1);
    chk("one_alloc_index", bus.alloc_index, 0);
    chk("one_alloc_instr", bus.alloc_instr, 64'h0050_0093);
    chk("one_count",       bus.count, 1);
    chk("one_issue_early", bus.issue_valid, 0);
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    tick();
    chk("one_alloc_drop",  bus.alloc_valid, 0);
    chk("one_alloc_zero",  bus.alloc_instr, 0);
    chk("one_issue_t1",    bus.issue_valid, 0);
    tick();
    chk("one_issue_valid", bus.issue_valid, 1);
    chk("one_issue_index", bus.issue_index, 0);
    chk("one_issue_instr", bus.issue_instr, 64'h0050_0093);
    tick();
    chk("one_rel_valid",   bus.release_valid, 1);
    chk("one_rel_index",   bus.release_index, 0);
    chk("one_issue_drop",  bus.issue_valid, 0);
    chk("one_count0",      bus.count, 0);
    chk("one_empty",       bus.empty, 1);
    tick();
    chk("one_rel_pulse",   bus.release_valid, 0);

    // Fill all 16 slots with nothing eligible
    bus.issue_ready = 1'b0;
    bus.ready_positions = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_instr = 32'h100 + 32'(i);
      tick();
    end
    chk("fill_full",       bus.full, 1);
    chk("fill_in_ready",   bus.in_ready, 0);
    chk("fill_count",      bus.count, 16);
    chk("fill_last_index", bus.alloc_index, 15);
    chk("fill_last_instr", bus.alloc_instr, 64'h10F);
    bus.in_instr = 32'hDEAD;
    tick();
    chk("fill_17_alloc",   bus.alloc_valid, 0);
    chk("fill_17_count",   bus.count, 16);
    bus.in_valid = 1'b0;
    bus.ready_positions = 16'h0040;
    tick();
    chk("fill_issue_valid", bus.issue_valid, 1);
    chk("fill_issue_index", bus.issue_index, 6);
    chk("fill_issue_instr", bus.issue_instr, 64'h106);
    bus.issue_ready = 1'b1;
    bus.ready_positions = '0;
    tick();
    chk("fill_rel_valid",  bus.release_valid, 1);
    chk("fill_rel_index",  bus.release_index, 6);
    chk("fill_count15",    bus.count, 15);
    chk("fill_in_ready1",  bus.in_ready, 1);
    chk("fill_issue_drop", bus.issue_valid, 0);
    bus.issue_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hABC;
    tick();
    chk("fill_reuse_valid", bus.alloc_valid, 1);
    chk("fill_reuse_index", bus.alloc_index, 6);
    chk("fill_refull",      bus.full, 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("fill_rst_count", bus.count, 0);

    // Dependency hold on slot 3
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_instr = 32'h300 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.ready_positions = 16'h0007;
    bus.issue_ready = 1'b1;
    tick();
    chk("dep_idx0", bus.issue_index, 0);
    tick();
    chk("dep_idx1", bus.issue_index, 1);
    tick();
    chk("dep_idx2", bus.issue_index, 2);
    tick();
    chk("dep_idle", bus.issue_valid, 0);
    tick();
    chk("dep_hold_a", (bus.issue_valid && bus.issue_index == 4'd3), 0);
    tick();
    chk("dep_hold_b", (bus.issue_valid && bus.issue_index == 4'd3), 0);
    bus.ready_positions = 16'h000F;
    tick();
    chk("dep_go_valid", bus.issue_valid, 1);
    chk("dep_go_index", bus.issue_index, 3);
    chk("dep_go_instr", bus.issue_instr, 64'h303);
    tick();
    chk("dep_rel_index", bus.release_index, 3);
    chk("dep_count0",    bus.count, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Round-robin: move rr to 2, then make slots 1, 2, 5 eligible together
    bus.ready_positions = '0;
    bus.issue_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_instr = 32'h200 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("rr_count6", bus.count, 6);
    bus.ready_positions = 16'h0002;
    tick();
    chk("rr_pre_index", bus.issue_index, 1);
    bus.ready_positions = '0;
    tick();
    chk("rr_pre_rel",   bus.release_index, 1);
    chk("rr_count5",    bus.count, 5);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h2F1;
    tick();
    chk("rr_realloc",   bus.alloc_index, 1);
    bus.in_valid = 1'b0;
    bus.ready_positions = 16'h0002;
    tick();
    chk("rr_pend_block", bus.issue_valid, 0);
    bus.ready_positions = 16'h0026;
    tick();
    chk("rr_first",  bus.issue_index, 2);
    tick();
    chk("rr_second", bus.issue_index, 5);
    tick();
    chk("rr_third",  bus.issue_index, 1);
    chk("rr_third_instr", bus.issue_instr, 64'h2F1);

    // Backpressure, then reset during the stall
    bus.issue_ready = 1'b0;
    bus.ready_positions = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", bus.issue_valid, 1);
      chk("bp_instr", bus.issue_instr, 64'h2F1);
      chk("bp_index", bus.issue_index, 1);
    end
    chk("bp_count", bus.count, 4);
    #2 rst = 1'b0;
    #1;
    chk("bp_rst_issue_valid", bus.issue_valid, 0);
    chk("bp_rst_count",       bus.count, 0);
    chk("bp_rst_empty",       bus.empty, 1);
    tick();
    rst = 1'b1;
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_issue", bus.issue_valid, 0);
    chk("post_rst_count", bus.count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
